// File: rtl/life_frame_scheduler.sv
`timescale 1ns/1ps
// Game of Life generation sequencer locked to 480p frame timing.
// Owns the double-buffered cell RAM port and arbitrates display vs updater.
module life_frame_scheduler #(
    parameter int ADDR_W   = 14,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 16
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              run,
    input  logic              step,
    input  logic [3:0]        period,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              upd_req,
    input  logic              upd_we,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_wdata,
    input  logic              upd_done,
    output logic              upd_start,
    output logic              disp_gnt,
    output logic              upd_gnt,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    output logic              front_bank,
    output logic [CNT_W-1:0]  gen_count,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LAUNCH,
        S_RUN,
        S_PEND
    } state_t;

    localparam logic [9:0] TICK_Y = 10'(V_ACTIVE);

    state_t            state_q, state_d;
    logic [3:0]        frame_q, frame_d;
    logic              pending_q, pending_d;
    logic              upd_start_q, upd_start_d;
    logic              disp_gnt_q, disp_gnt_d;
    logic              upd_gnt_q, upd_gnt_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_wdata_q, mem_wdata_d;
    logic              front_bank_q, front_bank_d;
    logic [CNT_W-1:0]  gen_count_q, gen_count_d;
    logic              busy_q, busy_d;
    logic              frame_tick;
    logic [4:0]        per_eff;

    always_comb begin
        frame_tick   = (sx == 10'd0) && (sy == TICK_Y);
        per_eff      = (period == 4'd0) ? 5'd1 : {1'b0, period};
        state_d      = state_q;
        frame_d      = frame_q;
        pending_d    = pending_q | step;
        front_bank_d = front_bank_q;
        gen_count_d  = gen_count_q;

        unique case (state_q)
            S_IDLE: begin
                frame_d = 4'd0;
                if (run || pending_q) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (!run && !pending_q) begin
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    if (({1'b0, frame_q} + 5'd1 >= per_eff) || pending_q) begin
                        state_d = S_LAUNCH;
                        frame_d = 4'd0;
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                if (upd_done) state_d = S_PEND;
            end
            S_PEND: begin
                if (frame_tick) begin
                    front_bank_d = ~front_bank_q;
                    gen_count_d  = gen_count_q + 1'b1;
                    state_d      = S_COUNT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a step arriving on the launch cycle itself queues the next generation
        if (state_d == S_LAUNCH) pending_d = step;

        upd_start_d = (state_d == S_LAUNCH);
        busy_d      = (state_d == S_LAUNCH) || (state_d == S_RUN)
                   || (state_d == S_PEND);

        disp_gnt_d  = 1'b0;
        upd_gnt_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        mem_addr_d  = mem_addr_q;
        if (disp_req) begin
            disp_gnt_d = 1'b1;
            mem_addr_d = {front_bank_q, disp_addr};
        end else if (upd_req && (state_q == S_RUN)) begin
            upd_gnt_d = 1'b1;
            if (upd_we) begin
                mem_addr_d  = {~front_bank_q, upd_addr};
                mem_we_d    = 1'b1;
                mem_wdata_d = upd_wdata;
            end else begin
                mem_addr_d = {front_bank_q, upd_addr};
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            pending_q    <= 1'b0;
            upd_start_q  <= 1'b0;
            disp_gnt_q   <= 1'b0;
            upd_gnt_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 1'b0;
            front_bank_q <= 1'b0;
            gen_count_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            pending_q    <= pending_d;
            upd_start_q  <= upd_start_d;
            disp_gnt_q   <= disp_gnt_d;
            upd_gnt_q    <= upd_gnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            front_bank_q <= front_bank_d;
            gen_count_q  <= gen_count_d;
            busy_q       <= busy_d;
        end
    end

    assign upd_start  = upd_start_q;
    assign disp_gnt   = disp_gnt_q;
    assign upd_gnt    = upd_gnt_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign front_bank = front_bank_q;
    assign gen_count  = gen_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_life_frame_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for life_frame_scheduler: frame ticks driven directly on sx/sy.
// gen_count is narrowed so the wrap boundary is reachable in a short run.
module tb_life_frame_scheduler;

    localparam int AW  = 14;
    localparam int CW  = 4;
    localparam int GAP = 120;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    sx = 10'd1;
    logic [9:0]    sy = 10'd0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic [3:0]    period = 4'd3;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          upd_req = 1'b0;
    logic          upd_we = 1'b0;
    logic [AW-1:0] upd_addr = '0;
    logic          upd_wdata = 1'b0;
    logic          upd_done;
    logic          resp_done = 1'b0;
    logic          man_done = 1'b0;
    logic          resp_en = 1'b0;
    logic          upd_start, disp_gnt, upd_gnt, mem_we, mem_wdata;
    logic          front_bank, busy;
    logic [AW:0]   mem_addr;
    logic [CW-1:0] gen_count;

    int n_cmp = 0;
    int n_err = 0;
    int inv_bad = 0;

    assign upd_done = resp_done | man_done;
    always #20 clk = ~clk;

    life_frame_scheduler #(.ADDR_W(AW), .V_ACTIVE(480), .CNT_W(CW)) dut (
        .clk_vga(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .run(run),
        .step(step), .period(period), .disp_req(disp_req),
        .disp_addr(disp_addr), .upd_req(upd_req), .upd_we(upd_we),
        .upd_addr(upd_addr), .upd_wdata(upd_wdata), .upd_done(upd_done),
        .upd_start(upd_start), .disp_gnt(disp_gnt), .upd_gnt(upd_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .front_bank(front_bank), .gen_count(gen_count), .busy(busy)
    );

    typedef struct {
        string       tag;
        logic        dg;
        logic        ug;
        logic        we;
        logic        wd;
        logic [AW:0] addr;
    } mexp_t;

    typedef struct {
        string         tag;
        logic          st;
        logic          fb;
        logic [CW-1:0] gc;
    } texp_t;

    mexp_t mq[$];
    texp_t tq[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ftick();
        sx = 10'd0;
        sy = 10'd480;
        cyc();
        sx = 10'd1;
        sy = 10'd0;
    endtask

    task automatic mem_expect(input string tag, input logic dg, input logic ug,
                              input logic we, input logic wd,
                              input logic [AW:0] a);
        mexp_t e;
        e.tag = tag; e.dg = dg; e.ug = ug; e.we = we; e.wd = wd; e.addr = a;
        mq.push_back(e);
    endtask

    task automatic mem_check();
        mexp_t e;
        if (mq.size() == 0) begin
            chk("mem_queue_empty", 1, 0);
            return;
        end
        e = mq.pop_front();
        chk({e.tag, "_dgnt"}, disp_gnt, e.dg);
        chk({e.tag, "_ugnt"}, upd_gnt, e.ug);
        chk({e.tag, "_we"}, mem_we, e.we);
        chk({e.tag, "_addr"}, mem_addr, e.addr);
        if (e.we) chk({e.tag, "_wdata"}, mem_wdata, e.wd);
    endtask

    task automatic tick_exp(input string tag, input logic st, input logic fb,
                            input logic [CW-1:0] gc);
        texp_t e;
        e.tag = tag; e.st = st; e.fb = fb; e.gc = gc;
        tq.push_back(e);
        ftick();
        e = tq.pop_front();
        chk({e.tag, "_start"}, upd_start, e.st);
        chk({e.tag, "_bank"}, front_bank, e.fb);
        chk({e.tag, "_gen"}, gen_count, e.gc);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
    endtask

    // updater stand-in: finish 100 cycles after each launch
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && upd_start) begin
                repeat (99) @(posedge clk);
                #1;
                resp_done = 1'b1;
                @(posedge clk);
                #1;
                resp_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (disp_gnt && upd_gnt) inv_bad++;
            if (mem_we && !upd_gnt) inv_bad++;
        end
    end

    initial begin
        int            seen;
        logic          fb_e;
        logic [CW-1:0] gc_e;
        bit            st_tbl[8];
        bit            fb_tbl[8];
        logic [CW-1:0] gc_tbl[8];

        // reset with run and step asserted
        rst_n = 1'b0; run = 1'b1; step = 1'b1; period = 4'd3;
        cyc(); cyc();
        chk("rst_upd_start", upd_start, 0);
        chk("rst_disp_gnt", disp_gnt, 0);
        chk("rst_upd_gnt", upd_gnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_front_bank", front_bank, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; step = 1'b0;
        seen = 0;
        repeat (20) begin
            cyc();
            if (upd_start || busy) seen++;
        end
        chk("no_start_before_tick", seen, 0);

        // free-running, period 3, updater finishes within the frame
        resp_en = 1'b1;
        st_tbl = '{0, 0, 1, 0, 0, 0, 1, 0};
        fb_tbl = '{0, 0, 0, 1, 1, 1, 1, 0};
        gc_tbl = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        for (int k = 0; k < 8; k++) begin
            tick_exp($sformatf("periodic_t%0d", k + 1), st_tbl[k], fb_tbl[k],
                     gc_tbl[k]);
            repeat (GAP) cyc();
        end

        // arbitration while RUN
        resp_en = 1'b0;
        tick_exp("arb_t1", 0, 0, 2);
        tick_exp("arb_t2", 0, 0, 2);
        tick_exp("arb_launch", 1, 0, 2);
        cyc();
        disp_req = 1'b1; disp_addr = 14'h123;
        upd_req = 1'b1; upd_we = 1'b1; upd_addr = 14'd5; upd_wdata = 1'b1;
        mem_expect("arb_both", 1, 0, 0, 0, {1'b0, 14'h123});
        cyc(); mem_check();
        disp_req = 1'b0;
        mem_expect("arb_upd_wr", 0, 1, 1, 1, {1'b1, 14'd5});
        cyc(); mem_check();
        upd_we = 1'b0; upd_addr = 14'd9;
        mem_expect("arb_upd_rd", 0, 1, 0, 0, {1'b0, 14'd9});
        cyc(); mem_check();
        upd_we = 1'b1; upd_addr = 14'h3FFF; upd_wdata = 1'b0;
        mem_expect("arb_upd_wr_max", 0, 1, 1, 0, {1'b1, 14'h3FFF});
        cyc(); mem_check();
        upd_req = 1'b0;
        mem_expect("arb_none", 0, 0, 0, 0, {1'b1, 14'h3FFF});
        cyc(); mem_check();
        pulse_done();
        upd_req = 1'b1; upd_we = 1'b1; upd_addr = 14'd7;
        mem_expect("arb_pend_nogrant", 0, 0, 0, 0, {1'b1, 14'h3FFF});
        cyc(); mem_check();
        upd_req = 1'b0;
        tick_exp("arb_swap", 0, 1, 3);
        disp_req = 1'b1; disp_addr = 14'h42;
        mem_expect("disp_new_front", 1, 0, 0, 0, {1'b1, 14'h42});
        cyc(); mem_check();
        disp_req = 1'b0;

        // single step, plus steps while busy queue exactly one more
        run = 1'b0;
        cyc(); cyc();
        step = 1'b1; cyc(); step = 1'b0;
        cyc(); cyc(); cyc();
        tick_exp("step_launch", 1, 1, 3);
        cyc();
        step = 1'b1; cyc(); step = 1'b0; cyc();
        step = 1'b1; cyc(); step = 1'b0;
        pulse_done();
        tick_exp("step_swap1", 0, 0, 4);
        tick_exp("queued_launch", 1, 0, 4);
        cyc();
        pulse_done();
        tick_exp("step_swap2", 0, 1, 5);
        cyc(); cyc();
        tick_exp("idle_no_launch", 0, 1, 5);
        chk("idle_busy", busy, 0);

        // updater request in IDLE, then period 0 up to the gen_count wrap
        upd_req = 1'b1; upd_we = 1'b1; upd_addr = 14'd11; upd_wdata = 1'b1;
        mem_expect("idle_upd_req", 0, 0, 0, 0, {1'b1, 14'h42});
        cyc(); mem_check();
        upd_req = 1'b0;
        period = 4'd0; run = 1'b1;
        cyc();
        fb_e = 1'b1; gc_e = 4'd5;
        for (int i = 0; i < 11; i++) begin
            tick_exp($sformatf("p0_launch%0d", i), 1, fb_e, gc_e);
            cyc();
            pulse_done();
            fb_e = ~fb_e;
            gc_e = gc_e + 4'd1;
            tick_exp($sformatf("p0_swap%0d", i), 0, fb_e, gc_e);
        end
        chk("gen_wrap_zero", gen_count, 0);

        // reset in the middle of a generation
        tick_exp("pre_rst_launch", 1, 0, 0);
        cyc();
        pulse_done();
        tick_exp("pre_rst_swap", 0, 1, 1);
        resp_en = 1'b1;
        tick_exp("rst_run_launch", 1, 1, 1);
        cyc();
        upd_req = 1'b1; upd_we = 1'b0; upd_addr = 14'd2;
        cyc();
        chk("pre_rst_upd_gnt", upd_gnt, 1);
        rst_n = 1'b0; run = 1'b0;
        cyc();
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_bank", front_bank, 0);
        chk("midrun_rst_upd_gnt", upd_gnt, 0);
        chk("midrun_rst_gen", gen_count, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (110) begin
            cyc();
            if (busy || upd_gnt || upd_start) seen++;
        end
        chk("late_done_ignored", seen, 0);
        upd_req = 1'b0;
        tick_exp("post_rst_tick", 0, 0, 0);
        chk("invariants", inv_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
